// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : aes_pkg                                                            |
// | Shared AES-128 types, round-control FSM encoding and GF(2^8) helpers.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int NUM_ROUNDS_C = 10;

    typedef logic [127:0] block_t;
    typedef logic [3:0]   round_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } aes_ctl_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), followed by the FIPS affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            inv = gfMul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : aes_round_datapath                                               |
// | One combinational AES round: SubBytes, ShiftRows, optional MixColumns, ARK.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_round_datapath
    import aes_pkg::*;
(
    input  block_t i_state,
    input  block_t i_rkey,
    input  logic   i_finalRnd,
    output block_t o_nextState
);

    block_t w_subBytes;
    block_t w_shiftRows;
    block_t w_mixCols;

    // Byte i sits at [127-8*i -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_byte
            localparam int c_row = i % 4;
            localparam int c_col = i / 4;
            localparam int c_src = 4 * ((c_col + c_row) % 4) + c_row;
            assign w_subBytes[127-8*i -: 8]  = sbox(i_state[127-8*i -: 8]);
            assign w_shiftRows[127-8*i -: 8] = w_subBytes[127-8*c_src -: 8];
        end
        for (genvar c = 0; c < 4; c++) begin : g_mixCol
            assign w_mixCols[127-32*c -: 32] = mixColumn(w_shiftRows[127-32*c -: 32]);
        end
    endgenerate

    assign o_nextState = (i_finalRnd ? w_shiftRows : w_mixCols) ^ i_rkey;

endmodule
`default_nettype wire

// File: rtl/aes_round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : aes_round_controller                                             |
// | Sequences one AES-128 encryption, one round per clock, fetching round keys.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_round_controller
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_C,
    parameter int BLOCK_W    = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plaintext,
    output logic               ready,
    output logic               busy,
    output logic               rkey_req,
    output logic [3:0]         rkey_idx,
    input  logic               rkey_valid,
    input  logic [BLOCK_W-1:0] rkey,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               done
);

    localparam round_idx_t c_lastRound = round_idx_t'(NUM_ROUNDS - 1);
    localparam round_idx_t c_finalIdx  = round_idx_t'(NUM_ROUNDS);

    aes_ctl_state_t r_fsm, w_fsmNext;
    round_idx_t     r_ctr, w_ctrNext;
    block_t         r_state, w_stateNext;
    block_t         r_ciphertext, w_ctNext;
    block_t         w_roundOut;

    aes_round_datapath u_datapath (
        .i_state     (r_state),
        .i_rkey      (rkey),
        .i_finalRnd  (r_fsm == FINAL),
        .o_nextState (w_roundOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= IDLE;
            r_ctr        <= '0;
            r_state      <= '0;
            r_ciphertext <= '0;
        end else begin
            r_fsm        <= w_fsmNext;
            r_ctr        <= w_ctrNext;
            r_state      <= w_stateNext;
            r_ciphertext <= w_ctNext;
        end
    end

    // Every key-consuming state holds all registers while rkey_valid is low.
    always_comb begin
        w_fsmNext   = r_fsm;
        w_ctrNext   = r_ctr;
        w_stateNext = r_state;
        w_ctNext    = r_ciphertext;
        case (r_fsm)
            IDLE: begin
                if (start) begin
                    w_stateNext = plaintext;
                    w_ctrNext   = '0;
                    w_fsmNext   = INIT;
                end
            end
            INIT: begin
                if (rkey_valid) begin
                    w_stateNext = r_state ^ rkey;
                    w_ctrNext   = round_idx_t'(1);
                    w_fsmNext   = ROUND;
                end
            end
            ROUND: begin
                if (rkey_valid) begin
                    w_stateNext = w_roundOut;
                    w_ctrNext   = r_ctr + round_idx_t'(1);
                    if (r_ctr == c_lastRound) w_fsmNext = FINAL;
                end
            end
            FINAL: begin
                if (rkey_valid) begin
                    w_ctNext  = w_roundOut;
                    w_fsmNext = DONE;
                end
            end
            DONE:    w_fsmNext = IDLE;
            default: w_fsmNext = IDLE;
        endcase
    end

    assign ready      = (r_fsm == IDLE);
    assign busy       = ~ready;
    assign done       = (r_fsm == DONE);
    assign rkey_req   = (r_fsm == INIT) || (r_fsm == ROUND) || (r_fsm == FINAL);
    assign rkey_idx   = (r_fsm == FINAL) ? c_finalIdx :
                        (r_fsm == ROUND) ? r_ctr      : round_idx_t'(0);
    assign ciphertext = r_ciphertext;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_aes_round_controller                                          |
// | Directed FIPS-197 vectors with a key-schedule model answering key requests.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_round_controller;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] expCt;
        int           stallIdx;
        int           stallLen;
        int           expLat;
        bit           poke;
    } vec_t;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst, start, rkey_valid, ready, busy, rkey_req, done;
    logic         stallReq;
    logic [3:0]   rkey_idx;
    logic [127:0] plaintext, rkey, ciphertext;
    logic [127:0] rkTab [0:10];
    logic [7:0]   expT [0:255];
    logic [7:0]   logT [0:255];
    int           nCmp = 0;
    int           nBad = 0;
    vec_t         vecs [0:4];

    aes_round_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .ready      (ready),
        .busy       (busy),
        .rkey_req   (rkey_req),
        .rkey_idx   (rkey_idx),
        .rkey_valid (rkey_valid),
        .rkey       (rkey),
        .ciphertext (ciphertext),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign rkey_valid = rkey_req & ~stallReq;
    assign rkey       = (rkey_idx <= 4'd10) ? rkTab[rkey_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic       hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Inverse through log/antilog tables over generator 3.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] v;
        v = (x == 8'h00) ? 8'h00 : expT[(255 - int'(logT[x])) % 255];
        return v ^ rol(v, 1) ^ rol(v, 2) ^ rol(v, 3) ^ rol(v, 4) ^ 8'h63;
    endfunction

    task automatic buildTables();
        expT[0] = 8'h01;
        for (int i = 0; i < 255; i++) begin
            logT[expT[i]] = 8'(i);
            expT[i+1]     = gmul(expT[i], 8'h03);
        end
    endtask

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rkTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called just after the accept edge; returns at the first negedge with done high.
    task automatic serviceUntilDone(input int stallIdx, input int stallLen, input bit poke,
                                    output int lat, output int seqErr, output int expIdx);
        int stalled;
        lat = 0; seqErr = 0; expIdx = 0; stalled = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke) start = (lat == 3 || lat == 8);
            if (done) break;
            if (!rkey_req || ready || !busy || rkey_idx != 4'(expIdx)) seqErr++;
            if (rkey_idx == 4'(stallIdx) && stalled < stallLen) begin
                stallReq = 1'b1;
                stalled++;
            end else begin
                stallReq = 1'b0;
                expIdx++;
            end
        end
        stallReq = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int lat, seqErr, nIdx;
        expandKey(v.key);
        @(negedge clk);
        check({tag, " ready before start"}, 128'(ready), 128'd1);
        start = 1'b1;
        plaintext = v.pt;
        @(posedge clk);
        #1 start = 1'b0;
        serviceUntilDone(v.stallIdx, v.stallLen, v.poke, lat, seqErr, nIdx);
        check({tag, " latency"}, 128'(lat), 128'(v.expLat));
        check({tag, " rkey_idx sequence errors"}, 128'(seqErr), 128'd0);
        check({tag, " keys consumed"}, 128'(nIdx), 128'd11);
        check({tag, " ciphertext"}, ciphertext, v.expCt);
        check({tag, " busy/ready/req in done"}, {ready, busy, rkey_req}, 128'b010);
        @(negedge clk);
        check({tag, " done/ready after pulse"}, {done, ready}, 128'b01);
        check({tag, " ciphertext holds"}, ciphertext, v.expCt);
    endtask

    initial begin
        int lat, seqErr, nIdx, guard, nDone;
        vecs[0] = '{K1, P1, C1, -1, 0, 12, 1'b0};
        vecs[1] = '{K2, P2, C2,  5, 3, 15, 1'b0};
        vecs[2] = '{K1, P1, C1, -1, 0, 12, 1'b1};
        vecs[3] = '{K2, P2, C2,  0, 1, 13, 1'b0};
        vecs[4] = '{K1, P1, C1, 10, 2, 14, 1'b0};

        rst = 1'b1; start = 1'b0; stallReq = 1'b0; plaintext = '0;
        buildTables();
        expandKey(K1);
        #12;
        check("reset ready/busy/done/req", {ready, busy, done, rkey_req}, 128'b1000);
        check("reset rkey_idx", 128'(rkey_idx), 128'd0);
        check("reset ciphertext", ciphertext, 128'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].poke) begin
                nDone = 0;
                repeat (15) begin
                    @(negedge clk);
                    if (done || !ready) nDone++;
                end
                check("ignored starts left no queued block", 128'(nDone), 128'd0);
            end
        end

        // Asynchronous reset in the middle of a block.
        expandKey(K1);
        @(negedge clk);
        start = 1'b1; plaintext = P1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (rkey_idx != 4'd6 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("abort reached rkey_idx 6", 128'(guard < 50), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("abort ready/busy/done/req", {ready, busy, done, rkey_req}, 128'b1000);
        check("abort ciphertext cleared", ciphertext, 128'd0);
        @(negedge clk) rst = 1'b0;
        nDone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) nDone++;
        end
        check("abort no done pulse", 128'(nDone), 128'd0);
        runVector(vecs[1], "after abort");

        // Back-to-back blocks with start held high.
        expandKey(K1);
        @(negedge clk);
        start = 1'b1; plaintext = P1;
        @(posedge clk);
        #1;
        serviceUntilDone(-1, 0, 1'b0, lat, seqErr, nIdx);
        check("b2b first latency", 128'(lat), 128'd12);
        check("b2b first ciphertext", ciphertext, C1);
        expandKey(K2);
        plaintext = P2;
        @(negedge clk);
        check("b2b idle gap ready", 128'(ready), 128'd1);
        check("b2b ciphertext held in idle", ciphertext, C1);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b second accepted", 128'(busy), 128'd1);
        check("b2b ciphertext held after accept", ciphertext, C1);
        serviceUntilDone(-1, 0, 1'b0, lat, seqErr, nIdx);
        check("b2b done spacing", 128'(lat + 1), 128'd13);
        check("b2b second sequence errors", 128'(seqErr), 128'd0);
        check("b2b second ciphertext", ciphertext, C2);
        @(negedge clk);
        check("b2b idle after second", {done, ready}, 128'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
